// File: rtl/sobel_pkg.sv
// Shared sizing helpers and window-position constants for the 3x3 edge-detect datapath.
package sobel_pkg;

  localparam int DATA_W_DEF = 24;
  localparam int IMG_W_DEF  = 640;
  localparam int IMG_H_DEF  = 480;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Row-major window slots; row 0 is the oldest line, column 0 the leftmost pixel.
  typedef enum logic [3:0] {
    WIN_00, WIN_01, WIN_02,
    WIN_10, WIN_11, WIN_12,
    WIN_20, WIN_21, WIN_22
  } win_pos_e;

  localparam int WIN_ROWS = 3;
  localparam int WIN_COLS = 3;

endpackage

// File: rtl/sobel_line_buffer.sv
// One image line of pixel storage: write and read share one address, read returns the old word.
// Read is combinational from the current address, so the caller sees old data in the writing cycle; never stalls.
module sobel_line_buffer #(
  parameter int DEPTH  = 640,
  parameter int DATA_W = 24
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/sobel_window_gen.sv
// Builds 3x3 neighbourhoods from a raster pixel stream using two line buffers.
// One cycle from accepting edge to window/centre/strobe outputs; no backpressure, every pixel is accepted.
module sobel_window_gen
  import sobel_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int IMG_W  = IMG_W_DEF,
  parameter int IMG_H  = IMG_H_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  input  logic                      in_sof,
  input  logic [DATA_W-1:0]         in_data,
  output logic                      win_valid,
  output logic [DATA_W-1:0]         x00,
  output logic [DATA_W-1:0]         x01,
  output logic [DATA_W-1:0]         x02,
  output logic [DATA_W-1:0]         x10,
  output logic [DATA_W-1:0]         x11,
  output logic [DATA_W-1:0]         x12,
  output logic [DATA_W-1:0]         x20,
  output logic [DATA_W-1:0]         x21,
  output logic [DATA_W-1:0]         x22,
  output logic [cnt_w(IMG_W)-1:0]   ctr_col,
  output logic [cnt_w(IMG_H)-1:0]   ctr_row,
  output logic                      frame_done
);

  localparam int CW = cnt_w(IMG_W);
  localparam int RW = cnt_w(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  logic [CW-1:0] col_q, col_d, eff_col;
  logic [RW-1:0] row_q, row_d, eff_row;
  logic [CW-1:0] ctr_col_q;
  logic [RW-1:0] ctr_row_q;
  logic          win_valid_q, frame_done_q;
  logic [2:0][2:0][DATA_W-1:0] win_q;
  logic [DATA_W-1:0] lb0_rd, lb1_rd;

  // A qualified start-of-frame overrides the running counters for this pixel.
  assign eff_col = (in_valid && in_sof) ? '0 : col_q;
  assign eff_row = (in_valid && in_sof) ? '0 : row_q;

  always_comb begin
    col_d = eff_col + CW'(1);
    row_d = eff_row;
    if (eff_col == COL_LAST) begin
      col_d = '0;
      row_d = (eff_row == ROW_LAST) ? '0 : eff_row + RW'(1);
    end
  end

  sobel_line_buffer #(.DEPTH(IMG_W), .DATA_W(DATA_W)) u_lb0 (
    .clk   (clk),
    .we    (in_valid),
    .addr  (eff_col[$clog2(IMG_W)-1:0]),
    .wdata (in_data),
    .rdata (lb0_rd)
  );

  sobel_line_buffer #(.DEPTH(IMG_W), .DATA_W(DATA_W)) u_lb1 (
    .clk   (clk),
    .we    (in_valid),
    .addr  (eff_col[$clog2(IMG_W)-1:0]),
    .wdata (lb0_rd),
    .rdata (lb1_rd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q        <= '0;
      row_q        <= '0;
      ctr_col_q    <= '0;
      ctr_row_q    <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      win_q        <= '0;
    end else begin
      win_valid_q  <= in_valid && (eff_col >= COL_TWO) && (eff_row >= ROW_TWO);
      frame_done_q <= in_valid && (eff_col == COL_LAST) && (eff_row == ROW_LAST);
      if (in_valid) begin
        for (int r = 0; r < 3; r++) begin
          win_q[r][0] <= win_q[r][1];
          win_q[r][1] <= win_q[r][2];
        end
        win_q[0][2] <= lb1_rd;
        win_q[1][2] <= lb0_rd;
        win_q[2][2] <= in_data;
        ctr_col_q   <= eff_col - CW'(1);
        ctr_row_q   <= eff_row - RW'(1);
        col_q       <= col_d;
        row_q       <= row_d;
      end
    end
  end

  assign win_valid  = win_valid_q;
  assign frame_done = frame_done_q;
  assign ctr_col    = ctr_col_q;
  assign ctr_row    = ctr_row_q;
  assign x00 = win_q[0][0];
  assign x01 = win_q[0][1];
  assign x02 = win_q[0][2];
  assign x10 = win_q[1][0];
  assign x11 = win_q[1][1];
  assign x12 = win_q[1][2];
  assign x20 = win_q[2][0];
  assign x21 = win_q[2][1];
  assign x22 = win_q[2][2];

endmodule

// File: tb/tb_sobel_window_gen.sv
// Bench for sobel_window_gen on a 4x4 image: directed frames plus random gapped/resynced streams,
// checked against a frame-image reference that cuts each window straight out of the stored picture.
module tb_sobel_window_gen;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_sof = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          win_valid, frame_done;
  logic [DW-1:0] x00, x01, x02, x10, x11, x12, x20, x21, x22;
  logic [1:0]    ctr_col, ctr_row;

  sobel_window_gen #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof), .in_data(in_data),
    .win_valid(win_valid),
    .x00(x00), .x01(x01), .x02(x02), .x10(x10), .x11(x11), .x12(x12),
    .x20(x20), .x21(x21), .x22(x22),
    .ctr_col(ctr_col), .ctr_row(ctr_row), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int nwin   = 0;

  logic [DW-1:0] xo   [3][3];
  logic [DW-1:0] img  [H][W];
  logic [DW-1:0] held [3][3];
  logic          held_known = 1'b0;
  int            mrow = 0;
  int            mcol = 0;

  always_comb begin
    xo[0][0] = x00; xo[0][1] = x01; xo[0][2] = x02;
    xo[1][0] = x10; xo[1][1] = x11; xo[1][2] = x12;
    xo[2][0] = x20; xo[2][1] = x21; xo[2][2] = x22;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, got, exp);
    end
  endtask

  // Drive one cycle, update the picture model with the accepted pixel, then check outputs.
  task automatic cycle(input logic v, input logic s, input logic [DW-1:0] d);
    logic          exp_v;
    logic          exp_fd;
    int            exp_cc, exp_cr;
    logic [DW-1:0] ew [3][3];
    in_valid = v; in_sof = s; in_data = d;
    @(posedge clk);
    exp_v = 1'b0; exp_fd = 1'b0; exp_cc = 0; exp_cr = 0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) ew[r][c] = '0;
    if (v) begin
      if (s) begin mrow = 0; mcol = 0; end
      img[mrow][mcol] = d;
      if (mrow >= 2 && mcol >= 2) begin
        exp_v = 1'b1;
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++) ew[r][c] = img[mrow-2+r][mcol-2+c];
        exp_cc = mcol - 1;
        exp_cr = mrow - 1;
        exp_fd = (mrow == H-1) && (mcol == W-1);
      end
      mcol++;
      if (mcol == W) begin
        mcol = 0;
        mrow = (mrow == H-1) ? 0 : mrow + 1;
      end
    end
    #1;
    check_val("win_valid", win_valid, exp_v);
    check_val("frame_done", frame_done, exp_fd);
    if (exp_v) begin
      nwin++;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++) begin
          check_val($sformatf("x%0d%0d", r, c), xo[r][c], ew[r][c]);
          held[r][c] = ew[r][c];
        end
      check_val("ctr_col", ctr_col, exp_cc);
      check_val("ctr_row", ctr_row, exp_cr);
      held_known = 1'b1;
    end else if (v) begin
      held_known = 1'b0;
    end else if (held_known) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          check_val($sformatf("hold_x%0d%0d", r, c), xo[r][c], held[r][c]);
    end
  endtask

  task automatic apply_reset();
    #2;
    rst_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0;
    #1;
    check_val("rst_win_valid", win_valid, 0);
    check_val("rst_frame_done", frame_done, 0);
    check_val("rst_ctr_col", ctr_col, 0);
    check_val("rst_ctr_row", ctr_row, 0);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        check_val($sformatf("rst_x%0d%0d", r, c), xo[r][c], 0);
        held[r][c] = '0;
      end
    held_known = 1'b1;
    mrow = 0; mcol = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic pixels(input int count, input int gap, input logic sof_first);
    for (int i = 0; i < count; i++) begin
      cycle(1'b1, sof_first && (i == 0), DW'(((i / W) * 16) + (i % W)));
      repeat (gap) cycle(1'b0, 1'b0, '0);
    end
  endtask

  task automatic full_frame(input string tag, input int gap, input logic sof);
    nwin = 0;
    pixels(W*H, gap, sof);
    check_val(tag, nwin, (W-2)*(H-2));
  endtask

  initial begin
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) img[r][c] = '0;
    apply_reset();
    cycle(1'b0, 1'b0, '0);

    full_frame("cnt_continuous", 0, 1'b1);
    full_frame("cnt_gapped", 2, 1'b1);

    pixels(6, 0, 1'b1);
    full_frame("cnt_resync", 0, 1'b1);

    pixels(10, 0, 1'b1);
    apply_reset();
    full_frame("cnt_after_reset", 0, 1'b1);

    pixels(11, 0, 1'b1);
    apply_reset();
    full_frame("cnt_reset_nosof", 0, 1'b0);

    full_frame("cnt_b2b_first", 0, 1'b1);
    full_frame("cnt_b2b_second", 0, 1'b0);

    for (int i = 0; i < 600; i++) begin
      logic v, s;
      v = ($urandom_range(0, 9) < 7);
      s = v && ($urandom_range(0, 39) == 0);
      cycle(v, s, DW'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
